// File: rtl/rng_if.sv
// Request/result bus between the dice datapath (master) and the rng engine (slave).
interface rng_if;
  logic        start;
  logic [31:0] result;
  logic        done;

  modport master (output start, input result, input done);
  modport slave  (input start, output result, output done);
endinterface

// File: rtl/rng.sv
// xorshift32 engine: a start request runs ROUNDS steps and publishes the state with a done pulse.
// Optional RNG_FREERUN_EN: the state also steps every IDLE cycle (timing-dependent entropy).
module rng #(
  parameter logic [31:0] SEED   = 32'h0000_0001,
  parameter int unsigned ROUNDS = 1
) (
  input  logic clk,
  input  logic reset,
  rng_if.slave bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 8;
  localparam logic [W-1:0]  SEED_EFF   = (SEED == '0) ? W'(1) : SEED;
  localparam logic [CW-1:0] LAST_COUNT = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e          fsm_q,    fsm_d;
  logic [W-1:0]  state_q,  state_d;
  logic [W-1:0]  result_q, result_d;
  logic          done_q,   done_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [W-1:0]  stepped;
  logic [W-1:0]  stepped_safe;

  function automatic logic [W-1:0] xorshift32(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Zero-lock guard: a zero state would stick forever, so substitute 1.
  always_comb begin
    stepped      = xorshift32(state_q);
    stepped_safe = (stepped == '0) ? W'(1) : stepped;
  end

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    result_d = result_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    case (fsm_q)
      IDLE: begin
`ifdef RNG_FREERUN_EN
        state_d = stepped_safe;
`endif
        if (bus.start) begin
          fsm_d = RUN;
          cnt_d = '0;
        end
      end
      RUN: begin
        state_d = stepped_safe;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_COUNT) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        result_d = state_q;
        done_d   = 1'b1;
        fsm_d    = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q    <= IDLE;
      state_q  <= SEED_EFF;
      result_q <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_rng.sv
// Randomized self-checking bench for rng: three instances (ROUNDS 1, 2, 7; one with SEED=0).
module tb_rng;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rng_if if0 ();
  rng_if if1 ();
  rng_if if2 ();

  rng #(.SEED(32'h0000_0001), .ROUNDS(1)) u_rng0 (.clk(clk), .reset(reset), .bus(if0.slave));
  rng #(.SEED(32'h0000_0001), .ROUNDS(2)) u_rng1 (.clk(clk), .reset(reset), .bus(if1.slave));
  rng #(.SEED(32'h0000_0000), .ROUNDS(7)) u_rng2 (.clk(clk), .reset(reset), .bus(if2.slave));

  int checks = 0;
  int errors = 0;
  logic [31:0] mstate [3];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference step from the algorithm definition, including the zero substitution.
  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    if (y == 32'h0) y = 32'h1;
    return y;
  endfunction

  function automatic int rounds_of(input int k);
    case (k)
      0: return 1;
      1: return 2;
      default: return 7;
    endcase
  endfunction

  function automatic logic get_done(input int k);
    case (k)
      0: return if0.done;
      1: return if1.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic [31:0] get_result(input int k);
    case (k)
      0: return if0.result;
      1: return if1.result;
      default: return if2.result;
    endcase
  endfunction

  task automatic set_start(input int k, input logic v);
    case (k)
      0: if0.start = v;
      1: if1.start = v;
      default: if2.start = v;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) mstate[k] = 32'h1;
  endtask

  // One request on instance k; busy-cycle start noise must be ignored.
  task automatic req(input int k, input bit noise);
    int r;
    logic [31:0] exp_v;
    r = rounds_of(k);
    exp_v = mstate[k];
    for (int i = 0; i < r; i++) exp_v = xs(exp_v);
    set_start(k, 1'b1);
    tick();
    for (int i = 0; i <= r; i++) begin
      set_start(k, noise ? 1'($urandom_range(0, 1)) : 1'b0);
      chk_eq("busy_no_done", 32'(get_done(k)), 32'h0);
      if (i == r) set_start(k, 1'b0);
      tick();
    end
    chk_eq("done_pulse", 32'(get_done(k)), 32'h1);
    chk_eq("result", get_result(k), exp_v);
    mstate[k] = exp_v;
    tick();
    chk_eq("done_low_after", 32'(get_done(k)), 32'h0);
    chk_eq("result_held", get_result(k), exp_v);
  endtask

  initial begin
    logic [31:0] exp_v;
    reset = 1'b1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;
    do_reset();

    for (int k = 0; k < 3; k++) begin
      chk_eq("reset_result", get_result(k), 32'h0);
      chk_eq("reset_done", 32'(get_done(k)), 32'h0);
    end
    for (int i = 0; i < 10; i++) begin
      chk_eq("idle_no_done", 32'({if2.done, if1.done, if0.done}), 32'h0);
      tick();
    end

`ifdef RNG_FREERUN_EN
    do_reset();
    tick();
    tick();
    tick();
    exp_v = 32'h1;
    for (int i = 0; i < 5; i++) exp_v = xs(exp_v);
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    chk_eq("fr_busy", 32'(if0.done), 32'h0);
    tick();
    chk_eq("fr_busy", 32'(if0.done), 32'h0);
    tick();
    chk_eq("fr_done", 32'(if0.done), 32'h1);
    chk_eq("fr_result", if0.result, exp_v);
    chk_eq("fr_differs", 32'(if0.result != 32'h0004_2021), 32'h1);
`else
    req(0, 1'b0);
    chk_eq("first_value", if0.result, 32'h0004_2021);
    req(0, 1'b0);
    chk_eq("second_value", if0.result, 32'h0408_0601);
    req(1, 1'b0);
    chk_eq("rounds2_value", if1.result, 32'h0408_0601);
    req(2, 1'b0);

    // start held: accept every ROUNDS+2 = 3 edges, done two edges after each accept.
    set_start(0, 1'b1);
    for (int n = 0; n < 23; n++) begin
      if (n == 20) set_start(0, 1'b0);
      tick();
      chk_eq("hold_done", 32'(if0.done), 32'((n % 3) == 2 && n <= 20));
      if ((n % 3) == 2 && n <= 20) begin
        mstate[0] = xs(mstate[0]);
        chk_eq("hold_result", if0.result, mstate[0]);
        chk_eq("hold_nonzero", 32'(if0.result != 32'h0), 32'h1);
      end
    end

    // Reset aborts a run in progress: no done, result cleared, sequence restarts.
    set_start(2, 1'b1);
    tick();
    set_start(2, 1'b0);
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk_eq("abort_no_done", 32'({if2.done, if1.done, if0.done}), 32'h0);
      chk_eq("abort_result", if2.result, 32'h0);
      tick();
    end
    req(0, 1'b0);
    chk_eq("restart_value", if0.result, 32'h0004_2021);
    req(2, 1'b0);

    for (int it = 0; it < 40; it++) begin
      int k;
      int gap;
      k = int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, 4));
      for (int g = 0; g < gap; g++) begin
        chk_eq("gap_no_done", 32'({if2.done, if1.done, if0.done}), 32'h0);
        tick();
      end
      req(k, 1'b1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
